// File: rtl/veggie_motion.sv
// veggie_motion: per-frame motion and life-cycle controller for one veggie sprite.
// Launches from a random point on the bottom edge, integrates a parabolic flight
// one step per frame, bounces off the side walls, latches the split event and
// pulses gone_out when the veggie falls out of the bottom of the screen.
// Optional feature macro: VEGGIE_SPLIT_KICK_EN (split stops the rise and flips vx).
// Handshake note: there is no valid/ready traffic here; frame_done_in and split_in
// are single-cycle strobes sampled on the rising clock edge, and every output is
// driven from registered state, so a change shows one cycle after the strobe edge.
module veggie_motion #(
   parameter int SCREEN_W       = 1024,
   parameter int SCREEN_H       = 768,
   parameter int SPRITE_HALF    = 64,
   parameter int GRAVITY        = 1,
   parameter int VY_LAUNCH_MIN  = 16,
   parameter int VY_MAX         = 31,
   parameter int RESPAWN_FRAMES = 30
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              frame_done_in,
   input  logic              enable_in,
   input  logic [15:0]       random_in,
   input  logic              split_in,
   output logic [10:0]       x_out,
   output logic [9:0]        y_out,
   output logic              active_out,
   output logic              split_out,
   output logic              gone_out,
   output logic [1:0]        state_dbg_out,
   output logic signed [4:0] vx_dbg_out,
   output logic signed [6:0] vy_dbg_out
);

   localparam int CNT_W = $clog2(RESPAWN_FRAMES);

   localparam logic signed [12:0] X_MIN     = 13'(SPRITE_HALF);
   localparam logic signed [12:0] X_MAX     = 13'(SCREEN_W - SPRITE_HALF);
   localparam logic signed [11:0] Y_EXIT    = 12'(SCREEN_H + SPRITE_HALF);
   localparam logic signed [11:0] Y_START   = 12'(SCREEN_H - 1);
   localparam logic signed [11:0] Y_CLAMP   = 12'sd1023;
   localparam logic signed [6:0]  VY_MAX_S  = 7'(VY_MAX);
   localparam logic signed [6:0]  GRAV_S    = 7'(GRAVITY);
   localparam logic [10:0]        X_RESET   = 11'(SCREEN_W / 2);
   localparam logic [10:0]        X_LAUNCH  = 11'(2 * SPRITE_HALF);
   localparam logic [6:0]         VY_L_MIN  = 7'(VY_LAUNCH_MIN);
   localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(RESPAWN_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_FLY    = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [10:0]           x_q, x_d;
   logic signed [11:0]    y_q, y_d;
   logic signed [4:0]     vx_q, vx_d;
   logic signed [6:0]     vy_q, vy_d;
   logic                  split_q, split_d;
   logic                  gone_q, gone_d;

   logic signed [12:0]    x_sum;
   logic signed [11:0]    y_sum;
   logic signed [6:0]     vy_grav;
   logic                  exit_hit;
   logic                  split_take;

   // vx lives in -8..7, so the reflection of -8 is pinned to +7 to stay in range.
   function automatic logic signed [4:0] neg_vx(input logic signed [4:0] v);
      if (v == -5'sd8) begin
         neg_vx = 5'sd7;
      end else begin
         neg_vx = -v;
      end
   endfunction

   // Candidate next-frame position, gravity step and exit test, all from old values.
   always_comb begin
      x_sum    = $signed({2'b00, x_q}) + $signed({{8{vx_q[4]}}, vx_q});
      y_sum    = y_q + $signed({{5{vy_q[6]}}, vy_q});
      vy_grav  = (vy_q >= VY_MAX_S) ? VY_MAX_S : vy_q + GRAV_S;
      exit_hit = (vy_q > 7'sd0) && (y_sum >= Y_EXIT);
   end

   // State register and datapath registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= ST_WAIT;
         cnt_q   <= '0;
         x_q     <= X_RESET;
         y_q     <= Y_START;
         vx_q    <= '0;
         vy_q    <= '0;
         split_q <= 1'b0;
         gone_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         vx_q    <= vx_d;
         vy_q    <= vy_d;
         split_q <= split_d;
         gone_q  <= gone_d;
      end
   end

   // Next-state logic: respawn countdown, launch, flight integration, bounce, exit, split.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      x_d        = x_q;
      y_d        = y_q;
      vx_d       = vx_q;
      vy_d       = vy_q;
      split_d    = split_q;
      gone_d     = 1'b0;
      // Exit takes priority over a split arriving on the same frame.
      split_take = (state_q == ST_FLY) && split_in && !split_q &&
                   !(frame_done_in && exit_hit);

      case (state_q)
         ST_WAIT: begin
            if (frame_done_in && enable_in) begin
               if (cnt_q == '0) begin
                  state_d = ST_LAUNCH;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end

         ST_LAUNCH: begin
            x_d     = X_LAUNCH + {2'b00, random_in[8:0]};
            y_d     = Y_START;
            vx_d    = $signed({1'b0, random_in[12:9]} - 5'd8);
            vy_d    = $signed(7'd0 - (VY_L_MIN + {4'b0000, random_in[15:13]}));
            split_d = 1'b0;
            state_d = ST_FLY;
         end

         ST_FLY: begin
            if (frame_done_in) begin
               if (exit_hit) begin
                  // Position and velocity hold; only the life-cycle moves on.
                  gone_d  = 1'b1;
                  state_d = ST_WAIT;
                  cnt_d   = CNT_RELOAD;
               end else begin
                  if (x_sum < X_MIN) begin
                     x_d  = X_MIN[10:0];
                     vx_d = neg_vx(vx_q);
                  end else if (x_sum > X_MAX) begin
                     x_d  = X_MAX[10:0];
                     vx_d = neg_vx(vx_q);
                  end else begin
                     x_d = x_sum[10:0];
                  end
                  y_d  = y_sum;
                  vy_d = vy_grav;
               end
            end
         end

         default: begin
            state_d = ST_WAIT;
         end
      endcase

      // Split is layered on top of the frame step so a coincident frame uses pre-split vy.
      if (split_take) begin
         split_d = 1'b1;
`ifdef VEGGIE_SPLIT_KICK_EN
         if (vy_d < 7'sd0) begin
            vy_d = 7'sd0;
         end
         vx_d = neg_vx(vx_d);
`else
`endif
      end
   end

   // Output mapping: y is clamped into the 10-bit screen coordinate.
   always_comb begin
      if (y_q < 12'sd0) begin
         y_out = 10'd0;
      end else if (y_q > Y_CLAMP) begin
         y_out = 10'd1023;
      end else begin
         y_out = y_q[9:0];
      end
      x_out         = x_q;
      active_out    = (state_q == ST_FLY);
      split_out     = split_q;
      gone_out      = gone_q;
      state_dbg_out = state_q;
      vx_dbg_out    = vx_q;
      vy_dbg_out    = vy_q;
   end

endmodule

// File: tb/tb_veggie_motion.sv
// tb_veggie_motion: directed bench for veggie_motion with hand-computed trajectories.
module tb_veggie_motion;

   logic              clk;
   logic              rst;
   logic              frame_done;
   logic              enable;
   logic [15:0]       random;
   logic              split;
   logic [10:0]       x_out;
   logic [9:0]        y_out;
   logic              active_out;
   logic              split_out;
   logic              gone_out;
   logic [1:0]        state_dbg;
   logic signed [4:0] vx_dbg;
   logic signed [6:0] vy_dbg;

   int total;
   int bad;

`ifdef VEGGIE_SPLIT_KICK_EN
   localparam int EXP_SPLIT_VX = -4;
   localparam int EXP_SPLIT_VY = 0;
   localparam int EXP_EXIT_N   = 21;
   localparam int EXP_EXIT_Y   = 822;
`else
   localparam int EXP_SPLIT_VX = 4;
   localparam int EXP_SPLIT_VY = -10;
   localparam int EXP_EXIT_N   = 34;
   localparam int EXP_EXIT_Y   = 830;
`endif

   veggie_motion dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .frame_done_in (frame_done),
      .enable_in     (enable),
      .random_in     (random),
      .split_in      (split),
      .x_out         (x_out),
      .y_out         (y_out),
      .active_out    (active_out),
      .split_out     (split_out),
      .gone_out      (gone_out),
      .state_dbg_out (state_dbg),
      .vx_dbg_out    (vx_dbg),
      .vy_dbg_out    (vy_dbg)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // Drivers: inputs change on the falling edge, outputs are sampled there too.
   task automatic frame_pulse(input logic with_split);
      @(negedge clk);
      frame_done = 1'b1;
      split      = with_split;
      @(negedge clk);
      frame_done = 1'b0;
      split      = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame_pulse(1'b0);
   endtask

   task automatic split_pulse();
      @(negedge clk);
      split = 1'b1;
      @(negedge clk);
      split = 1'b0;
   endtask

   task automatic test_reset();
      total++; if (x_out !== 11'd512) begin bad++; $display("FAIL reset_x got=%0d want=512", x_out); end
      total++; if (y_out !== 10'd767) begin bad++; $display("FAIL reset_y got=%0d want=767", y_out); end
      total++; if (active_out !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", active_out); end
      total++; if (split_out !== 1'b0) begin bad++; $display("FAIL reset_split got=%b want=0", split_out); end
      total++; if (gone_out !== 1'b0) begin bad++; $display("FAIL reset_gone got=%b want=0", gone_out); end
      total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
      total++; if (vx_dbg !== 5'sd0 || vy_dbg !== 7'sd0) begin bad++; $display("FAIL reset_v got=%0d/%0d want=0/0", vx_dbg, vy_dbg); end
   endtask

   task automatic test_launch();
      enable = 1'b1;
      random = 16'h0000;
      frame_pulse(1'b0);
      total++; if (state_dbg !== 2'd1) begin bad++; $display("FAIL launch_state got=%0d want=1", state_dbg); end
      total++; if (active_out !== 1'b0) begin bad++; $display("FAIL launch_active_early got=%b want=0", active_out); end
      @(negedge clk);
      total++; if (x_out !== 11'd128) begin bad++; $display("FAIL launch_x got=%0d want=128", x_out); end
      total++; if (y_out !== 10'd767) begin bad++; $display("FAIL launch_y got=%0d want=767", y_out); end
      total++; if (vx_dbg !== -5'sd8) begin bad++; $display("FAIL launch_vx got=%0d want=-8", vx_dbg); end
      total++; if (vy_dbg !== -7'sd16) begin bad++; $display("FAIL launch_vy got=%0d want=-16", vy_dbg); end
      total++; if (active_out !== 1'b1) begin bad++; $display("FAIL launch_active got=%b want=1", active_out); end
   endtask

   task automatic test_bounce();
      frame_pulse(1'b0);
      total++; if (x_out !== 11'd120 || y_out !== 10'd751) begin bad++; $display("FAIL f1_pos got=%0d,%0d want=120,751", x_out, y_out); end
      total++; if (vy_dbg !== -7'sd15) begin bad++; $display("FAIL f1_vy got=%0d want=-15", vy_dbg); end
      frames(7);
      total++; if (x_out !== 11'd64 || y_out !== 10'd667) begin bad++; $display("FAIL f8_pos got=%0d,%0d want=64,667", x_out, y_out); end
      total++; if (vx_dbg !== -5'sd8) begin bad++; $display("FAIL f8_vx got=%0d want=-8", vx_dbg); end
      frame_pulse(1'b0);
      total++; if (x_out !== 11'd64 || y_out !== 10'd659) begin bad++; $display("FAIL bounce_pos got=%0d,%0d want=64,659", x_out, y_out); end
      total++; if (vx_dbg !== 5'sd7) begin bad++; $display("FAIL bounce_vx got=%0d want=7", vx_dbg); end
      total++; if (vy_dbg !== -7'sd7) begin bad++; $display("FAIL bounce_vy got=%0d want=-7", vy_dbg); end
      frame_pulse(1'b0);
      total++; if (x_out !== 11'd71 || y_out !== 10'd652) begin bad++; $display("FAIL f10_pos got=%0d,%0d want=71,652", x_out, y_out); end
   endtask

   task automatic test_exit_respawn();
      for (int i = 0; i < 26; i++) begin
         frame_pulse(1'b0);
         total++; if (gone_out !== 1'b0) begin bad++; $display("FAIL early_gone frame=%0d got=%b want=0", i + 11, gone_out); end
      end
      total++; if (y_out !== 10'd821 || active_out !== 1'b1) begin bad++; $display("FAIL f36 got=y%0d,a%b want=y821,a1", y_out, active_out); end
      frame_pulse(1'b0);
      total++; if (gone_out !== 1'b1) begin bad++; $display("FAIL exit_gone got=%b want=1", gone_out); end
      total++; if (active_out !== 1'b0 || state_dbg !== 2'd0) begin bad++; $display("FAIL exit_state got=a%b,s%0d want=a0,s0", active_out, state_dbg); end
      total++; if (y_out !== 10'd821) begin bad++; $display("FAIL exit_hold_y got=%0d want=821", y_out); end
      @(negedge clk);
      total++; if (gone_out !== 1'b0) begin bad++; $display("FAIL gone_width got=%b want=0", gone_out); end
      random = 16'h792C;
      for (int i = 0; i < 29; i++) begin
         frame_pulse(1'b0);
         total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL respawn_early pulse=%0d got=%0d want=0", i + 1, state_dbg); end
      end
      frame_pulse(1'b0);
      total++; if (state_dbg !== 2'd1) begin bad++; $display("FAIL respawn_30 got=%0d want=1", state_dbg); end
      @(negedge clk);
      total++; if (x_out !== 11'd428 || vx_dbg !== 5'sd4 || vy_dbg !== -7'sd19) begin bad++; $display("FAIL relaunch got=x%0d,vx%0d,vy%0d want=x428,vx4,vy-19", x_out, vx_dbg, vy_dbg); end
   endtask

   task automatic test_split();
      int  n;
      logic got;
      frames(9);
      total++; if (x_out !== 11'd464 || y_out !== 10'd632 || vy_dbg !== -7'sd10) begin bad++; $display("FAIL pre_split got=x%0d,y%0d,vy%0d want=x464,y632,vy-10", x_out, y_out, vy_dbg); end
      split_pulse();
      total++; if (split_out !== 1'b1) begin bad++; $display("FAIL split_set got=%b want=1", split_out); end
      total++; if (vx_dbg !== EXP_SPLIT_VX || vy_dbg !== EXP_SPLIT_VY) begin bad++; $display("FAIL split_v got=%0d/%0d want=%0d/%0d", vx_dbg, vy_dbg, EXP_SPLIT_VX, EXP_SPLIT_VY); end
      split_pulse();
      total++; if (vx_dbg !== EXP_SPLIT_VX || vy_dbg !== EXP_SPLIT_VY || split_out !== 1'b1) begin bad++; $display("FAIL split_repeat got=%0d/%0d/%b want=%0d/%0d/1", vx_dbg, vy_dbg, split_out, EXP_SPLIT_VX, EXP_SPLIT_VY); end
      total++; if (x_out !== 11'd464 || y_out !== 10'd632) begin bad++; $display("FAIL split_pos got=%0d,%0d want=464,632", x_out, y_out); end
      n   = 0;
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         frame_pulse(1'b0);
         n++;
         if (gone_out === 1'b1) got = 1'b1;
      end
      total++; if (got !== 1'b1 || n != EXP_EXIT_N) begin bad++; $display("FAIL split_exit_frames got=%0d(seen=%b) want=%0d", n, got, EXP_EXIT_N); end
      total++; if (y_out !== 10'(EXP_EXIT_Y) || split_out !== 1'b1) begin bad++; $display("FAIL split_exit_pos got=y%0d,s%b want=y%0d,s1", y_out, split_out, EXP_EXIT_Y); end
      random = 16'h0000;
      frames(30);
      @(negedge clk);
      total++; if (split_out !== 1'b0 || active_out !== 1'b1 || x_out !== 11'd128) begin bad++; $display("FAIL split_clear got=s%b,a%b,x%0d want=s0,a1,x128", split_out, active_out, x_out); end
   endtask

   task automatic test_split_exit();
      frames(36);
      total++; if (y_out !== 10'd821) begin bad++; $display("FAIL c36_y got=%0d want=821", y_out); end
      frame_pulse(1'b1);
      total++; if (gone_out !== 1'b1 || split_out !== 1'b0) begin bad++; $display("FAIL split_at_exit got=g%b,s%b want=g1,s0", gone_out, split_out); end
      split_pulse();
      total++; if (split_out !== 1'b0 || state_dbg !== 2'd0) begin bad++; $display("FAIL split_in_wait got=s%b,st%0d want=s0,st0", split_out, state_dbg); end
   endtask

   task automatic test_async_reset();
      frames(30);
      @(negedge clk);
      frames(5);
      total++; if (active_out !== 1'b1 || x_out === 11'd512) begin bad++; $display("FAIL prereset_fly got=a%b,x%0d want=a1,x!=512", active_out, x_out); end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++; if (x_out !== 11'd512 || y_out !== 10'd767) begin bad++; $display("FAIL async_pos got=%0d,%0d want=512,767", x_out, y_out); end
      total++; if (active_out !== 1'b0 || split_out !== 1'b0 || gone_out !== 1'b0 || state_dbg !== 2'd0) begin bad++; $display("FAIL async_flags got=a%b,s%b,g%b,st%0d want=0,0,0,0", active_out, split_out, gone_out, state_dbg); end
      total++; if (vx_dbg !== 5'sd0 || vy_dbg !== 7'sd0) begin bad++; $display("FAIL async_v got=%0d/%0d want=0/0", vx_dbg, vy_dbg); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_enable_hold();
      int launched;
      enable   = 1'b0;
      launched = 0;
      for (int i = 0; i < 100; i++) begin
         frame_pulse(1'b0);
         if (state_dbg !== 2'd0) launched++;
      end
      total++; if (launched != 0) begin bad++; $display("FAIL enable_hold got=%0d non-wait samples want=0", launched); end
      enable = 1'b1;
      frame_pulse(1'b0);
      total++; if (state_dbg !== 2'd1) begin bad++; $display("FAIL enable_resume got=%0d want=1", state_dbg); end
   endtask

   // Sequencer and final report
   initial begin
      total      = 0;
      bad        = 0;
      rst        = 1'b1;
      frame_done = 1'b0;
      enable     = 1'b0;
      random     = 16'h0000;
      split      = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_launch();
      test_bounce();
      test_exit_respawn();
      test_split();
      test_split_exit();
      test_async_reset();
      test_enable_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
